// File: rtl/store_unit_pkg.sv
// Shared types for the RV32I store-execution controller.
package store_unit_pkg;

    typedef enum logic [1:0] {
        sk_sb      = 2'd0,
        sk_sh      = 2'd1,
        sk_sw      = 2'd2,
        sk_invalid = 2'd3
    } store_kind_t;

endpackage

// File: rtl/store_unit.sv
// Store-execution controller: turns one decoded store into one or two
// lane-positioned write beats on the 32-bit data-memory port.
module store_unit
    import store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  store_kind_t req_kind,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;

    logic [31:0] b1_addr;
    logic [31:0] b1_wdata;
    logic [3:0]  b1_be;
    logic        split_q;

    logic [3:0]  mask4;
    logic [31:0] data_t;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic [31:0] beat0_addr;
    logic [31:0] beat1_addr;

    // Lane placement of the incoming request; only feeds capture registers.
    always_comb begin
        mask4  = 4'b0000;
        data_t = 32'd0;
        case (req_kind)
            sk_sb: begin
                mask4  = 4'b0001;
                data_t = {24'd0, req_data[7:0]};
            end
            sk_sh: begin
                mask4  = 4'b0011;
                data_t = {16'd0, req_data[15:0]};
            end
            sk_sw: begin
                mask4  = 4'b1111;
                data_t = req_data;
            end
            default: begin
                mask4  = 4'b0000;
                data_t = 32'd0;
            end
        endcase
        mask8      = 8'(mask4) << req_addr[1:0];
        data64     = 64'(data_t) << {req_addr[1:0], 3'b000};
        beat0_addr = {req_addr[31:2], 2'b00};
        beat1_addr = beat0_addr + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            b1_addr   <= 32'd0;
            b1_wdata  <= 32'd0;
            b1_be     <= 4'd0;
            split_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_kind == sk_invalid) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            mem_req   <= 1'b1;
                            mem_addr  <= beat0_addr;
                            mem_wdata <= data64[31:0];
                            mem_be    <= mask8[3:0];
                            b1_addr   <= beat1_addr;
                            b1_wdata  <= data64[63:32];
                            b1_be     <= mask8[7:4];
                            split_q   <= |mask8[7:4];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_gnt) begin
                        if (split_q) begin
                            state     <= BEAT1;
                            mem_addr  <= b1_addr;
                            mem_wdata <= b1_wdata;
                            mem_be    <= b1_be;
                        end else begin
                            state     <= RESP;
                            mem_req   <= 1'b0;
                            mem_addr  <= 32'd0;
                            mem_wdata <= 32'd0;
                            mem_be    <= 4'd0;
                            done      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_gnt) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_be    <= 4'd0;
                        done      <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    split_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus random stores
// checked cycle by cycle against a byte-by-byte reference model.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    store_kind_t req_kind;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        done;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference beats for the current request.
    logic [31:0] e_addr  [2];
    logic [31:0] e_wdata [2];
    logic [3:0]  e_be    [2];
    int          e_nb;

    store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_gnt   (mem_gnt),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Walk the store byte by byte; each byte lands in the word that holds its address.
    task automatic model(input store_kind_t k, input logic [31:0] a, input logic [31:0] d);
        int          n;
        logic [31:0] ba;
        logic [31:0] w;
        int          lane;
        e_nb = 0;
        for (int j = 0; j < 2; j++) begin
            e_addr[j]  = 32'd0;
            e_wdata[j] = 32'd0;
            e_be[j]    = 4'd0;
        end
        n = (k == sk_sb) ? 1 : (k == sk_sh) ? 2 : (k == sk_sw) ? 4 : 0;
        for (int i = 0; i < n; i++) begin
            ba   = a + 32'(i);
            w    = ba & 32'hFFFF_FFFC;
            lane = int'(ba[1:0]);
            if (e_nb == 0 || w != e_addr[e_nb-1]) begin
                e_addr[e_nb] = w;
                e_nb++;
            end
            e_be[e_nb-1][lane]           = 1'b1;
            e_wdata[e_nb-1][8*lane +: 8] = d[8*i +: 8];
        end
    endtask

    // Issue one store and follow it to completion; stall_n<0 means random grants.
    task automatic do_store(input store_kind_t k, input logic [31:0] a, input logic [31:0] d,
                            input int stall_n);
        int   waitc = 0;
        int   bi    = 0;
        int   sc    = 0;
        bit   fin   = 1'b0;
        logic g;
        model(k, a, d);
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_kind  = k;
        req_addr  = a;
        req_data  = d;
        mem_gnt   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_kind  = store_kind_t'(2'($urandom));
        for (int c = 1; c <= 40 && !fin; c++) begin
            if (bi < e_nb) begin
                chk("beat_req",   32'(mem_req),   32'd1);
                chk("beat_addr",  mem_addr,       e_addr[bi]);
                chk("beat_wdata", mem_wdata,      e_wdata[bi]);
                chk("beat_be",    32'(mem_be),    32'(e_be[bi]));
                chk("beat_ready", 32'(req_ready), 32'd0);
                chk("beat_busy",  32'(busy),      32'd1);
                chk("beat_done",  32'(done),      32'd0);
                g = (stall_n < 0) ? ($urandom_range(0, 3) != 0) : (sc >= stall_n);
                if (g) begin
                    bi++;
                    sc = 0;
                end else begin
                    sc++;
                end
                mem_gnt = g;
                @(negedge clk);
            end else begin
                chk("resp_done",  32'(done),      32'd1);
                chk("resp_err",   32'(err),       32'(k == sk_invalid));
                chk("resp_req",   32'(mem_req),   32'd0);
                chk("resp_addr",  mem_addr,       32'd0);
                chk("resp_be",    32'(mem_be),    32'd0);
                chk("resp_ready", 32'(req_ready), 32'd0);
                mem_gnt = 1'($urandom);
                @(negedge clk);
                chk("post_done",  32'(done),      32'd0);
                chk("post_err",   32'(err),       32'd0);
                chk("post_ready", 32'(req_ready), 32'd1);
                chk("post_busy",  32'(busy),      32'd0);
                fin = 1'b1;
            end
        end
        chk("store_timeout", 32'(fin), 32'd1);
        mem_gnt = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        store_kind_t k;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_kind  = sk_sb;
        req_addr  = 32'd0;
        req_data  = 32'd0;
        mem_gnt   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_req",   32'(mem_req),   32'd0);
        chk("rst_addr",  mem_addr,       32'd0);
        chk("rst_wdata", mem_wdata,      32'd0);
        chk("rst_be",    32'(mem_be),    32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Directed cases from the store test plan.
        do_store(sk_sb,      32'h0000_1003, 32'hAABB_CCDD, 0);
        do_store(sk_sw,      32'h0000_2002, 32'h1122_3344, 0);
        do_store(sk_sh,      32'h0000_0004, 32'hFFFF_5678, 3);
        do_store(sk_invalid, 32'h0000_0010, 32'h1234_5678, 0);
        do_store(sk_sw,      32'hFFFF_FFFE, 32'hDEAD_BEEF, 0);
        do_store(sk_sh,      32'h0000_0103, 32'hCAFE_BABE, 1);
        do_store(sk_sw,      32'h0000_0200, 32'h0BAD_F00D, 2);

        // Reset while a split store stalls in its second beat.
        model(sk_sw, 32'h0000_3001, 32'h5566_7788);
        req_valid = 1'b1;
        req_kind  = sk_sw;
        req_addr  = 32'h0000_3001;
        req_data  = 32'h5566_7788;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rb_beat0_addr", mem_addr, e_addr[0]);
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("rb_beat1_req",  32'(mem_req), 32'd1);
        chk("rb_beat1_be",   32'(mem_be),  32'(e_be[1]));
        mem_gnt = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("rb_req",   32'(mem_req),   32'd0);
        chk("rb_busy",  32'(busy),      32'd0);
        chk("rb_done",  32'(done),      32'd0);
        chk("rb_ready", 32'(req_ready), 32'd0);
        chk("rb_addr",  mem_addr,       32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rb_done2", 32'(done),      32'd0);
        chk("rb_req2",  32'(mem_req),   32'd0);
        chk("rb_busy2", 32'(busy),      32'd0);
        chk("rb_ready2", 32'(req_ready), 32'd1);
        do_store(sk_sb, 32'h0000_4002, 32'h0000_00A5, 0);

        // Random stores with random grants and idle gaps.
        for (int r = 0; r < 60; r++) begin
            k = store_kind_t'(2'($urandom_range(0, 3)));
            a = $urandom;
            if (r % 5 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            do_store(k, a, $urandom, -1);
            repeat ($urandom_range(0, 2)) begin
                mem_gnt = 1'($urandom);
                @(negedge clk);
            end
            mem_gnt = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
